// File: rtl/chan_initiator_if.sv
// Byte-stream and channel-side handshake bundle for chan_initiator.
// master = the initiator block, slave = whatever surrounds it (byte source/sink, channel logic).
interface chan_initiator_if;
   logic [7:0] rxData_in;
   logic       rxValid_in;
   logic       rxReady_out;
   logic [7:0] txData_out;
   logic       txValid_out;
   logic       txReady_in;
   logic [6:0] chanAddr_out;
   logic [7:0] h2fData_out;
   logic       h2fValid_out;
   logic       h2fReady_in;
   logic [7:0] f2hData_in;
   logic       f2hValid_in;
   logic       f2hReady_out;

   modport master (
      input  rxData_in, rxValid_in, txReady_in, h2fReady_in, f2hData_in, f2hValid_in,
      output rxReady_out, txData_out, txValid_out, chanAddr_out,
             h2fData_out, h2fValid_out, f2hReady_out
   );

   modport slave (
      output rxData_in, rxValid_in, txReady_in, h2fReady_in, f2hData_in, f2hValid_in,
      input  rxReady_out, txData_out, txValid_out, chanAddr_out,
             h2fData_out, h2fValid_out, f2hReady_out
   );
endinterface

// File: rtl/chan_initiator.sv
// Byte-stream to 128-channel bridge: parses cmd/length/data and drives chanAddr/h2f/f2h.
// Optional running byte checksum output enabled by defining CHAN_INITIATOR_CKSUM_EN.
//
// state   | meaning
// S_IDLE  | waiting for a command byte
// S_LEN3  | expecting length byte 3 (MSB)
// S_LEN2  | expecting length byte 2
// S_LEN1  | expecting length byte 1
// S_LEN0  | expecting length byte 0 (LSB), then dispatch
// S_WRITE | rx bytes pass straight through to h2f
// S_READ  | f2h bytes pass straight through to tx
module chan_initiator #(
   parameter int LEN_WIDTH = 32
) (
   input  logic        clk_in,
   input  logic        reset_in,
   chan_initiator_if.master bus,
   output logic        busy_out
`ifdef CHAN_INITIATOR_CKSUM_EN
   ,
   output logic [15:0] cksumData_out
`endif
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN3, S_LEN2, S_LEN1, S_LEN0, S_WRITE, S_READ
   } state_t;

   state_t               state_q, state_d;
   logic [LEN_WIDTH-1:0] count_q;
   logic [LEN_WIDTH-1:0] len_shift;
   logic [6:0]           chan_q;
   logic                 dir_q;
   logic                 rx_rdy, h2f_vld, tx_vld, f2h_rdy;
   logic                 wr_xfer, rd_xfer, last_byte;

   // Wire length is always 4 bytes; bits shifted above LEN_WIDTH fall off the top.
   if (LEN_WIDTH > 8) begin : g_wide_len
      assign len_shift = {count_q[LEN_WIDTH-9:0], bus.rxData_in};
   end else begin : g_narrow_len
      assign len_shift = bus.rxData_in;
   end

   assign wr_xfer   = bus.rxValid_in & bus.h2fReady_in;
   assign rd_xfer   = bus.f2hValid_in & bus.txReady_in;
   assign last_byte = (count_q == LEN_WIDTH'(1));

   always_ff @(posedge clk_in) begin
      if (!reset_in) state_q <= S_IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      rx_rdy  = 1'b0;
      h2f_vld = 1'b0;
      tx_vld  = 1'b0;
      f2h_rdy = 1'b0;
      case (state_q)
         S_IDLE: begin
            rx_rdy = 1'b1;
            if (bus.rxValid_in) state_d = S_LEN3;
         end
         S_LEN3: begin
            rx_rdy = 1'b1;
            if (bus.rxValid_in) state_d = S_LEN2;
         end
         S_LEN2: begin
            rx_rdy = 1'b1;
            if (bus.rxValid_in) state_d = S_LEN1;
         end
         S_LEN1: begin
            rx_rdy = 1'b1;
            if (bus.rxValid_in) state_d = S_LEN0;
         end
         S_LEN0: begin
            rx_rdy = 1'b1;
            if (bus.rxValid_in) begin
               if (len_shift == '0) state_d = S_IDLE;
               else if (dir_q)      state_d = S_READ;
               else                 state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            rx_rdy  = bus.h2fReady_in;
            h2f_vld = bus.rxValid_in;
            if (wr_xfer && last_byte) state_d = S_IDLE;
         end
         S_READ: begin
            f2h_rdy = bus.txReady_in;
            tx_vld  = bus.f2hValid_in;
            if (rd_xfer && last_byte) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Strobes are forced to their idle values while reset is held, whatever state is registered.
   assign bus.rxReady_out  = reset_in & rx_rdy;
   assign bus.h2fValid_out = reset_in & h2f_vld;
   assign bus.txValid_out  = reset_in & tx_vld;
   assign bus.f2hReady_out = reset_in & f2h_rdy;
   assign bus.h2fData_out  = bus.rxData_in;
   assign bus.txData_out   = bus.f2hData_in;
   assign bus.chanAddr_out = chan_q;
   assign busy_out         = (state_q != S_IDLE);

`ifdef CHAN_INITIATOR_CKSUM_EN
   logic [15:0] cksum_q;
   assign cksumData_out = cksum_q;
`endif

   always_ff @(posedge clk_in) begin
      if (!reset_in) begin
         chan_q  <= '0;
         dir_q   <= 1'b0;
         count_q <= '0;
`ifdef CHAN_INITIATOR_CKSUM_EN
         cksum_q <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: if (bus.rxValid_in) begin
               chan_q  <= bus.rxData_in[6:0];
               dir_q   <= bus.rxData_in[7];
               count_q <= '0;
`ifdef CHAN_INITIATOR_CKSUM_EN
               cksum_q <= '0;
`endif
            end
            S_LEN3, S_LEN2, S_LEN1, S_LEN0: if (bus.rxValid_in) count_q <= len_shift;
            S_WRITE: if (wr_xfer) begin
               count_q <= count_q - LEN_WIDTH'(1);
`ifdef CHAN_INITIATOR_CKSUM_EN
               cksum_q <= cksum_q + {8'h00, bus.rxData_in};
`endif
            end
            S_READ: if (rd_xfer) begin
               count_q <= count_q - LEN_WIDTH'(1);
`ifdef CHAN_INITIATOR_CKSUM_EN
               cksum_q <= cksum_q + {8'h00, bus.f2hData_in};
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_chan_initiator.sv
// Randomized bench for chan_initiator: a command-level model predicts handshakes, data and checksum.
module tb_chan_initiator;
   logic clk_in = 1'b0;
   logic reset_in;
   always #5 clk_in = ~clk_in;

   chan_initiator_if u_if ();
   chan_initiator_if u_if8 ();
   logic busy, busy8;
`ifdef CHAN_INITIATOR_CKSUM_EN
   logic [15:0] cksum, cksum8;
`endif

   chan_initiator #(.LEN_WIDTH(32)) u_dut (
      .clk_in(clk_in), .reset_in(reset_in), .bus(u_if.master), .busy_out(busy)
`ifdef CHAN_INITIATOR_CKSUM_EN
      , .cksumData_out(cksum)
`endif
   );

   chan_initiator #(.LEN_WIDTH(8)) u_dut8 (
      .clk_in(clk_in), .reset_in(reset_in), .bus(u_if8.master), .busy_out(busy8)
`ifdef CHAN_INITIATOR_CKSUM_EN
      , .cksumData_out(cksum8)
`endif
   );

   int         n_chk = 0;
   int         n_pass = 0;
   bit         stall_en;
   logic [7:0] wr_fixed[$];
   logic [7:0] rd_fixed[$];
   logic [7:0] f2h_cur;
   logic [7:0] tr_bytes [7] = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h02, 8'h11, 8'h22};

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic bit coin();
      return !stall_en || ($urandom_range(3) != 0);
   endfunction

   // Runs one command; the model tracks header bytes seen and data bytes remaining.
   task automatic run_cmd(input logic [7:0] cmd, input logic [31:0] len, input int abort_at);
      logic [7:0]  rx_q[$];
      logic [7:0]  exp_h2f[$];
      logic [7:0]  b, h2f_obs, tx_obs;
      logic [31:0] rem;
      logic [15:0] sum;
      logic        dir, exp_rxr, exp_h2fv, exp_txv, exp_f2hr, exp_busy;
      int          hdr, ntx;
      bit          done;
      dir = cmd[7]; rem = len; sum = '0; hdr = 0; ntx = 0; done = 0;
      rx_q.push_back(cmd);
      for (int i = 3; i >= 0; i--) rx_q.push_back(len[i*8 +: 8]);
      if (!dir)
         for (int i = 0; i < int'(len); i++) begin
            b = (wr_fixed.size() > 0) ? wr_fixed.pop_front() : 8'($urandom);
            rx_q.push_back(b);
            exp_h2f.push_back(b);
         end
      if (rd_fixed.size() > 0) f2h_cur = rd_fixed.pop_front();
      for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
         @(negedge clk_in);
         u_if.rxValid_in  = (rx_q.size() > 0) && coin();
         u_if.rxData_in   = (rx_q.size() > 0) ? rx_q[0] : 8'($urandom);
         u_if.h2fReady_in = coin();
         u_if.txReady_in  = coin();
         u_if.f2hValid_in = coin();
         u_if.f2hData_in  = f2h_cur;
         #1;
         exp_rxr  = (hdr < 5) ? 1'b1 : (!dir && u_if.h2fReady_in);
         exp_h2fv = (hdr == 5) && !dir && u_if.rxValid_in;
         exp_txv  = (hdr == 5) && dir && u_if.f2hValid_in;
         exp_f2hr = (hdr == 5) && dir && u_if.txReady_in;
         exp_busy = (hdr > 0);
         check_eq("ctl{rxr,h2fv,txv,f2hr,busy}",
                  {27'd0, u_if.rxReady_out, u_if.h2fValid_out, u_if.txValid_out, u_if.f2hReady_out, busy},
                  {27'd0, exp_rxr, exp_h2fv, exp_txv, exp_f2hr, exp_busy});
         check_eq("h2f_pass", {24'd0, u_if.h2fData_out}, {24'd0, u_if.rxData_in});
         check_eq("tx_pass", {24'd0, u_if.txData_out}, {24'd0, u_if.f2hData_in});
         h2f_obs = u_if.h2fData_out;
         tx_obs  = u_if.txData_out;
         @(posedge clk_in);
         if (hdr < 5) begin
            if (u_if.rxValid_in) begin
               b = rx_q.pop_front();
               hdr++;
            end
         end else if (!dir) begin
            if (u_if.rxValid_in && u_if.h2fReady_in) begin
               b = exp_h2f.pop_front();
               check_eq("h2f_data", {24'd0, h2f_obs}, {24'd0, b});
               b = rx_q.pop_front();
               sum = sum + 16'(b);
               rem--;
            end
         end else if (u_if.f2hValid_in && u_if.txReady_in) begin
            check_eq("tx_data", {24'd0, tx_obs}, {24'd0, f2h_cur});
            sum = sum + 16'(f2h_cur);
            rem--;
            ntx++;
            f2h_cur = (rd_fixed.size() > 0) ? rd_fixed.pop_front() : 8'($urandom);
         end
         done = ((hdr == 5) && (rem == 0)) || ((abort_at > 0) && (ntx == abort_at));
      end
      check_eq("cmd_done", {31'd0, done}, 32'd1);
      if (abort_at == 0) begin
         #1;
         check_eq("chan_addr", {25'd0, u_if.chanAddr_out}, {25'd0, cmd[6:0]});
         check_eq("end_idle{busy,rxr}", {30'd0, busy, u_if.rxReady_out}, 32'd1);
`ifdef CHAN_INITIATOR_CKSUM_EN
         check_eq("cksum", {16'd0, cksum}, {16'd0, sum});
`endif
      end
   endtask

   initial begin
      int n8;
      reset_in = 1'b0;
      stall_en = 0;
      f2h_cur  = 8'($urandom);
      u_if.rxValid_in = 0;  u_if.rxData_in = 0;  u_if.txReady_in = 0;
      u_if.h2fReady_in = 0; u_if.f2hData_in = 0; u_if.f2hValid_in = 0;
      u_if8.rxValid_in = 0; u_if8.rxData_in = 0; u_if8.txReady_in = 0;
      u_if8.h2fReady_in = 0; u_if8.f2hData_in = 0; u_if8.f2hValid_in = 0;

      repeat (3) @(negedge clk_in);
      #1;
      check_eq("rst_rxr", {31'd0, u_if.rxReady_out}, 32'd0);
      check_eq("rst_chan", {25'd0, u_if.chanAddr_out}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk_in);
      reset_in = 1'b1;
      #1;
      check_eq("post_rst{rxr,h2fv,txv,f2hr}",
               {28'd0, u_if.rxReady_out, u_if.h2fValid_out, u_if.txValid_out, u_if.f2hReady_out}, 32'h8);

      wr_fixed = '{8'hAA, 8'hBB, 8'hCC};
      run_cmd(8'h01, 32'd3, 0);
`ifdef CHAN_INITIATOR_CKSUM_EN
      check_eq("cksum_aabbcc", {16'd0, cksum}, 32'h0231);
`endif
      rd_fixed = '{8'h5A, 8'h3C};
      run_cmd(8'h82, 32'd2, 0);
      run_cmd(8'h05, 32'd0, 0);
      run_cmd(8'h06, 32'd1, 0);

      stall_en = 1;
      run_cmd(8'h07, 32'd4, 0);
      repeat (30) begin
         logic [7:0] c;
         c = 8'($urandom);
         run_cmd(c, 32'($urandom_range(0, 6)), 0);
      end

      stall_en = 0;
      run_cmd(8'h83, 32'h100, 10);
      @(negedge clk_in);
      reset_in = 1'b0;
      u_if.rxValid_in = 0; u_if.f2hValid_in = 1; u_if.txReady_in = 1;
      #1;
      check_eq("midrst{rxr,txv,f2hr}",
               {29'd0, u_if.rxReady_out, u_if.txValid_out, u_if.f2hReady_out}, 32'd0);
      @(posedge clk_in);
      #1;
      check_eq("midrst_chan", {25'd0, u_if.chanAddr_out}, 32'd0);
      check_eq("midrst_busy{busy,rxr,txv}", {29'd0, busy, u_if.rxReady_out, u_if.txValid_out}, 32'd0);
      @(negedge clk_in);
      reset_in = 1'b1;
      u_if.f2hValid_in = 0;
      #1;
      check_eq("midrst_release_rxr", {31'd0, u_if.rxReady_out}, 32'd1);
      run_cmd(8'h09, 32'd2, 0);

      n8 = 0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk_in);
         u_if8.rxValid_in  = 1;
         u_if8.rxData_in   = tr_bytes[i];
         u_if8.h2fReady_in = 1;
         #1;
         if (u_if8.h2fValid_out && u_if8.h2fReady_in) begin
            n8++;
            check_eq("trunc_data", {24'd0, u_if8.h2fData_out}, {24'd0, tr_bytes[i]});
         end
      end
      @(negedge clk_in);
      u_if8.rxValid_in = 0;
      #1;
      check_eq("trunc_count", n8, 32'd2);
      check_eq("trunc_busy", {31'd0, busy8}, 32'd0);
      check_eq("trunc_chan", {25'd0, u_if8.chanAddr_out}, 32'd3);
`ifdef CHAN_INITIATOR_CKSUM_EN
      check_eq("trunc_cksum", {16'd0, cksum8}, 32'h0033);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/chan_initiator.md
Name: chan_initiator

Overview:
- Byte-stream-to-channel bridge; the initiator side of the 128-channel read/write interface.
- Parses a command stream from a generic byte source (UART, debug FIFO, etc.) and drives chanAddr/h2f/f2h transactions into the channel-register logic.
- Returns read data on an outbound byte stream.
- Lets channel logic be exercised without the FX2 comm block.

Parameters:
LEN_WIDTH, 32, internal transfer-counter width (8..32); wire length field is always 4 bytes, bits above LEN_WIDTH discarded

Ports:
clk_in  input  1  system clock, all logic on rising edge
reset_in  input  1  synchronous, active-low reset
rxData_in  input  8  inbound command/data byte
rxValid_in  input  1  inbound byte present
rxReady_out  output  1  block accepts inbound byte this cycle
txData_out  output  8  outbound read-data byte
txValid_out  output  1  outbound byte present
txReady_in  input  1  sink accepts outbound byte this cycle
chanAddr_out  output  7  selected channel (0-127)
h2fData_out  output  8  write data to channel logic
h2fValid_out  output  1  write byte valid
h2fReady_in  input  1  channel logic can take write byte
f2hData_in  input  8  read data from channel logic
f2hValid_in  input  1  channel logic has read byte
f2hReady_out  output  1  block takes read byte this cycle
busy_out  output  1  high in any state other than S_IDLE

Behaviour:
- Transfer rules: a byte moves on a port pair only when valid and ready are both high at a rising edge.
- Wire protocol, one command: cmd byte (bit7 = 1 read, 0 write; bits6:0 = channel), then 4 length bytes (big-endian), then data.
  - Write command: the data bytes follow on rx.
  - Read command: the data bytes are produced on tx.
- States:
  - S_IDLE: rxReady_out = 1. On cmd accept, register chanAddr_out <= rxData_in[6:0] and dir <= rxData_in[7], then go to S_LEN3.
  - S_LEN3, S_LEN2, S_LEN1, S_LEN0: rxReady_out = 1. Each accept shifts the byte into count (MSB first); S_LEN0 is last.
  - On S_LEN0 accept, with L = the assembled count:
    - L == 0: go to S_IDLE, no transaction.
    - dir = 0: go to S_WRITE.
    - dir = 1: go to S_READ.
  - S_WRITE (combinational pass-through, zero added latency):
    - h2fData_out = rxData_in; h2fValid_out = rxValid_in; rxReady_out = h2fReady_in.
    - Each transfer decrements count; transfer with count == 1 returns to S_IDLE.
  - S_READ (combinational pass-through):
    - txData_out = f2hData_in; txValid_out = f2hValid_in; f2hReady_out = txReady_in; rxReady_out = 0.
    - Each transfer decrements count; transfer with count == 1 returns to S_IDLE.
- Outside S_WRITE: h2fValid_out = 0. Outside S_READ: txValid_out = 0, f2hReady_out = 0. Outside S_IDLE and S_LENx: rxReady_out = 0 (except S_WRITE as above).
- h2fData_out = rxData_in and txData_out = f2hData_in at all times; only the valid strobes are gated.
- chanAddr_out holds its value after a command ends, until the next cmd byte is accepted.
- Stalls: either side may deassert valid or ready for any number of cycles. Count and state are held, no byte is lost or duplicated.
- Counter: LEN_WIDTH bits, no wrap, since decrement only occurs while count ≥ 1.
- Reset (reset_in = 0 at a clock edge, including mid-transfer):
  - state = S_IDLE, count = 0, chanAddr_out = 0, dir = 0.
  - All valid/ready outputs take their S_IDLE values: rxReady_out = 1 after release; while reset_in = 0, rxReady_out = 0.
  - Any partially transferred command is abandoned.
- Back-to-back commands: the cmd byte may be accepted the cycle after the last data transfer.

Optional Feature:
Macro: CHAN_INITIATOR_CKSUM_EN
- Defined:
  - Adds output port cksumData_out [15:0].
  - A 16-bit register accumulates the sum (mod 2^16) of every byte transferred in S_WRITE and S_READ.
  - Cleared to 0 on reset and when each cmd byte is accepted.
  - Value persists after the command ends.
- Undefined: port and register absent; behaviour otherwise identical.

Test Plan:
- Write: rx 0x01,00,00,00,03,AA,BB,CC with h2fReady_in = 1 -> chanAddr_out = 1; h2f transfers AA,BB,CC; busy_out falls after CC; cksumData_out = 0x0231.
- Read: rx 0x82,00,00,00,02; f2hData_in 0x5A then 0x3C -> tx emits 5A,3C; f2hReady_out mirrors txReady_in; returns to S_IDLE.
- Zero length: rx 0x05,00,00,00,00 -> no h2fValid_out/txValid_out pulses; chanAddr_out = 5; next cmd accepted next cycle.
- Stall: write length 4; h2fReady_in low for 3 cycles after byte 2 -> rxReady_out low for those cycles; exactly 4 h2f transfers in order.
- Reset mid-read: length 0x100, assert reset_in low after 10 bytes -> rxReady_out = 0 and txValid_out = 0 during reset; chanAddr_out = 0 after; a new write cmd then works normally.
- Large length / truncation: LEN_WIDTH = 8, length bytes 0x12,34,56,02 -> exactly 2 data bytes transferred.
